// File: rtl/trig_pkg.sv
// Shared types and widths for the trigger generator and capture side.
// State encoding plus default phase/pulse counter widths.
package trig_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 9;
  localparam int NUM_W_DEF = 8;

endpackage

// File: rtl/trig_pulse_gen_phase_timer.sv
// Loadable down-counter shared by the HIGH and LOW phases.
// Ports: clk, rst_n, clr, load, load_val, en (decrement), zero flag.
module phase_timer
  import trig_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/trig_pulse_gen.sv
// Burst/continuous trigger pulse generator with programmable high/low time.
// Ports: clk, rst_n, start, stop, high_cycles, low_cycles, num_pulses -> trig, fall_strb, busy, done, pulse_cnt.
module trig_pulse_gen
  import trig_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             trig,
  output logic             fall_strb,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulse_cnt
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] h_q, l_q;
  logic [NUM_W-1:0] n_q;
  logic [CNT_W-1:0] h_in, l_in;
  logic [CNT_W-1:0] ld_val;
  logic             ld, dec, clr, latch, inc;
  logic             fall_d, done_d;
  logic             zero;

  // Zero lengths behave as one cycle
  assign h_in = (high_cycles == '0) ? CNT_W'(1) : high_cycles;
  assign l_in = (low_cycles == '0) ? CNT_W'(1) : low_cycles;

  phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (ld),
    .load_val (ld_val),
    .en       (dec),
    .zero     (zero)
  );

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    ld_val  = '0;
    dec     = 1'b0;
    clr     = 1'b0;
    latch   = 1'b0;
    inc     = 1'b0;
    fall_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          latch   = 1'b1;
          ld      = 1'b1;
          ld_val  = h_in - CNT_W'(1);
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (zero) begin
          state_d = LOW;
          ld      = 1'b1;
          ld_val  = l_q - CNT_W'(1);
          inc     = 1'b1;
          fall_d  = 1'b1;
        end else begin
          dec = 1'b1;
        end
      end
      LOW: begin
        if (zero) begin
          // pulse_cnt already counts this pulse's falling edge
          if (n_q != '0 && pulse_cnt == n_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = HIGH;
            ld      = 1'b1;
            ld_val  = h_q - CNT_W'(1);
          end
        end else begin
          dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a start in IDLE
    if (stop) begin
      state_d = IDLE;
      ld      = 1'b0;
      dec     = 1'b0;
      clr     = 1'b1;
      latch   = 1'b0;
      inc     = 1'b0;
      fall_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      h_q       <= '0;
      l_q       <= '0;
      n_q       <= '0;
      pulse_cnt <= '0;
      trig      <= 1'b0;
      fall_strb <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      trig      <= (state_d == HIGH);
      busy      <= (state_d != IDLE);
      fall_strb <= fall_d;
      done      <= done_d;
      if (latch) begin
        h_q       <= h_in;
        l_q       <= l_in;
        n_q       <= num_pulses;
        pulse_cnt <= '0;
      end else if (inc) begin
        pulse_cnt <= pulse_cnt + NUM_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_trig_pulse_gen.sv
// Directed self-checking bench for trig_pulse_gen.
// Cycle c = c-th rising edge after the start sample; checks on negedge.
module tb_trig_pulse_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [8:0] high_cycles = '0;
  logic [8:0] low_cycles = '0;
  logic [7:0] num_pulses = '0;
  logic       trig, fall_strb, busy, done;
  logic [7:0] pulse_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  trig_pulse_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .num_pulses  (num_pulses),
    .trig        (trig),
    .fall_strb   (fall_strb),
    .busy        (busy),
    .done        (done),
    .pulse_cnt   (pulse_cnt)
  );

  // Stand-in for the capture counter: free-running 9-bit timestamp
  logic       cap_en = 1'b0;
  logic       trig_d = 1'b0;
  logic [8:0] fr = '0;
  logic [8:0] ts[$];

  always @(posedge clk) begin
    fr     <= fr + 9'd1;
    trig_d <= trig;
    if (cap_en && trig_d && !trig) ts.push_back(fr);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present config and a one-cycle start at this negedge (cycle 0)
  task automatic go(input int h, input int l, input int n);
    high_cycles = 9'(h);
    low_cycles  = 9'(l);
    num_pulses  = 8'(n);
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  initial begin
    int dn;
    int base;
    int cnt;
    tick();
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fall", fall_strb, 0);
    chk("rst_pcnt", pulse_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Reset mid-burst, during second HIGH (cycles 9-12)
    go(4, 4, 3);
    for (int c = 2; c <= 10; c++) tick();
    chk("t1_pre_trig", trig, 1);
    chk("t1_pre_pcnt", pulse_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_trig", trig, 0);
    chk("t1_async_busy", busy, 0);
    chk("t1_async_pcnt", pulse_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic burst H=3 L=5 N=2
    go(3, 5, 2);
    for (int c = 1; c <= 18; c++) begin
      chk($sformatf("t2_trig_c%0d", c), trig,
          int'((c >= 1 && c <= 3) || (c >= 9 && c <= 11)));
      chk($sformatf("t2_fall_c%0d", c), fall_strb,
          int'(c == 4 || c == 12));
      chk($sformatf("t2_busy_c%0d", c), busy, int'(c <= 16));
      chk($sformatf("t2_done_c%0d", c), done, int'(c == 17));
      if (c == 17) chk("t2_pcnt", pulse_cnt, 2);
      if (c < 18) tick();
    end

    // Zero lengths: toggle every cycle
    go(0, 0, 4);
    for (int c = 1; c <= 9; c++) begin
      if (c <= 8) chk($sformatf("t3_trig_c%0d", c), trig, c % 2);
      chk($sformatf("t3_done_c%0d", c), done, int'(c == 9));
      if (c == 9) chk("t3_pcnt", pulse_cnt, 4);
      tick();
    end

    // Continuous H=1 L=2, 300 periods, then stop
    go(1, 2, 0);
    dn = 0;
    cnt = 0;
    for (int c = 1; c <= 900; c++) begin
      if (done) dn++;
      if (fall_strb) cnt++;
      if (c == 764) chk("t4_pcnt_255", pulse_cnt, 255);
      if (c == 767) chk("t4_pcnt_wrap", pulse_cnt, 0);
      if (c < 900) tick();
    end
    chk("t4_falls", cnt, 300);
    chk("t4_no_done", dn, 0);
    chk("t4_pcnt_44", pulse_cnt, 44);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_stop_trig", trig, 0);
    chk("t4_stop_busy", busy, 0);
    chk("t4_stop_done", done, 0);
    chk("t4_stop_pcnt", pulse_cnt, 44);
    tick();

    // start+stop together in IDLE
    stop = 1'b1;
    go(2, 2, 1);
    stop = 1'b0;
    chk("t5_ss_busy", busy, 0);
    chk("t5_ss_trig", trig, 0);
    tick();
    chk("t5_ss_busy2", busy, 0);

    // start while busy ignored; start in done cycle accepted
    go(2, 3, 2);
    tick();
    high_cycles = 9'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    high_cycles = 9'd2;
    for (int c = 3; c <= 11; c++) begin
      chk($sformatf("t5_fall_c%0d", c), fall_strb, int'(c == 3 || c == 8));
      chk($sformatf("t5_done_c%0d", c), done, int'(c == 11));
      if (c < 11) tick();
    end
    num_pulses = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_restart_trig", trig, 1);
    chk("t5_restart_pcnt", pulse_cnt, 0);

    // Stop during HIGH: falling edge without strobe or count
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t5_abort_trig", trig, 0);
    chk("t5_abort_fall", fall_strb, 0);
    chk("t5_abort_pcnt", pulse_cnt, 0);
    tick();
    chk("t5_abort_fall2", fall_strb, 0);

    // Loopback into capture stand-in: H=100 L=156
    ts.delete();
    cap_en = 1'b1;
    go(100, 156, 4);
    base = 0;
    while (!done && base < 1200) begin
      tick();
      base++;
    end
    chk("t6_done_seen", int'(done), 1);
    tick();
    cap_en = 1'b0;
    chk("t6_ncap", ts.size(), 4);
    for (int i = 1; i < ts.size(); i++)
      chk($sformatf("t6_delta%0d", i), int'(9'(ts[i] - ts[i-1])), 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trig_pulse_gen.md
Name: trig_pulse_gen

Overview:
Programmable trigger generator that drives the trig line consumed by the 9-bit edge-capture counter.
- Produces a burst of pulses with configurable high time, low time and pulse count, or runs continuously.
- The capture side timestamps each trig falling edge, so this block exists to stimulate and calibrate it with known edge-to-edge intervals.

Parameters:
CNT_W, 9, width of the high/low phase-length inputs and the internal phase counter
NUM_W, 8, width of the pulse-count input and the pulse counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
stop  input  1  abort request; sampled in any state
high_cycles  input  CNT_W  trig high duration in clk cycles; 0 is treated as 1
low_cycles  input  CNT_W  trig low duration in clk cycles; 0 is treated as 1
num_pulses  input  NUM_W  pulses per burst; 0 means continuous until stop
trig  output  1  generated trigger, registered
fall_strb  output  1  one-cycle strobe in the first cycle trig is low after a high phase
busy  output  1  high while not in IDLE
done  output  1  one-cycle strobe when a finite burst completes normally
pulse_cnt  output  NUM_W  pulses completed in the current or last burst (counts falling edges)

Behaviour:
- Reset (async assert, sync release) forces the following:
  - state=IDLE, trig=0, fall_strb=0, busy=0, done=0, pulse_cnt=0.
  - Phase counter and latched config are 0.
- States: IDLE, HIGH, LOW.
- IDLE:
  - If start=1 and stop=0, latch high_cycles, low_cycles and num_pulses (zero lengths mapped to 1).
  - Clear pulse_cnt, load the phase counter with H-1 and go to HIGH.
  - trig=1 from the very next cycle, so the start-to-rising-edge latency is 1 clk.
  - Inputs that change after the latch have no effect until the next start.
- HIGH:
  - trig=1 for exactly H cycles, with the phase counter decrementing to 0.
  - On the last cycle, go to LOW and reload the counter with L-1.
  - pulse_cnt increments and fall_strb=1 in the first LOW cycle.
- LOW:
  - trig=0 for exactly L cycles.
  - On the last cycle, if num_pulses!=0 and pulse_cnt==num_pulses, go to IDLE with done=1 in the first IDLE cycle.
  - Otherwise go to HIGH and reload the counter with H-1.
- Edge spacing:
  - Falling-edge to falling-edge period is exactly H+L cycles.
  - The first falling edge occurs H+1 cycles after the start sample.
- Continuous mode (num_pulses=0): pulse_cnt wraps from 2^NUM_W-1 to 0; the burst never self-terminates.
- stop:
  - Any state: next cycle state=IDLE, trig=0, busy=0, done=0.
  - pulse_cnt holds its value; the phase counter is cleared.
  - Stop during HIGH creates a falling edge without fall_strb and without incrementing pulse_cnt.
- Simultaneous events:
  - start with stop in IDLE: stop wins and the block remains IDLE.
  - start while busy is ignored.
  - A start in the cycle done is asserted is accepted, because the block is already in IDLE.
- busy is the registered decode of state != IDLE.
- All outputs are registered, so there are no combinational input-to-output paths.
- Arithmetic is unsigned. The phase counter is CNT_W bits and never underflows because reload happens at 0.
- Maximum phase length is 2^CNT_W-1 cycles.

Decomposition:
- Shared package trig_pkg holds:
  - the state enum (IDLE=2'd0, HIGH=2'd1, LOW=2'd2);
  - default CNT_W and NUM_W constants, shared with the capture counter so timestamp widths match.
- One natural sub-module, phase_timer: a loadable down-counter with load value, enable and a zero flag.
  - It is instantiated once and reused for both phases.
- The FSM and the pulse counter live in the top module.

Test Plan:
1. Reset mid-burst: H=4, L=4, N=3; assert rst_n=0 during the second HIGH phase -> trig, busy and pulse_cnt go to 0 immediately, without waiting for clk.
2. Basic burst: H=3, L=5, N=2, start at cycle 0 -> expected response:
   - trig high cycles 1-3, low 4-8, high 9-11, low 12-16;
   - fall_strb at cycles 4 and 12;
   - done at cycle 17, pulse_cnt=2, busy low from cycle 17.
3. Zero lengths: H=0, L=0, N=4 -> trig toggles every cycle (period 2), done after 8 trig cycles, pulse_cnt=4.
4. Continuous plus stop: H=1, L=2, N=0; run 300 periods then pulse stop -> expected response:
   - pulse_cnt wraps past 255 to 44;
   - trig=0 and busy=0 one cycle after stop;
   - no done.
5. Collisions:
   - start+stop together in IDLE -> remains IDLE.
   - start during HIGH with new H=9 -> ignored; the period stays at the original H+L.
6. Loopback into the capture counter: H=100, L=156 repeated -> successive captured timestamps differ by exactly 256 modulo 512.
